linealizador_normalizador_core: RTL and testbench

LINEALIZADOR_NORMALIZADOR_CORE -- requirements
Module: linealizador_normalizador_core

---
 rtl/linealizador_normalizador_core.sv | 147 ++++++++++++++
 tb/tb_linealizador_normalizador_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/linealizador_normalizador_core.sv
// Two independent channels that apply gain and offset to a raw sample, saturate the sum
// to 32 bits, and convert it to IEEE-754 single precision with truncation.

module linealizador_normalizador_channel #(
   parameter logic [31:0] GAIN       = 32'h0001_0000,
   parameter logic [31:0] OFFSET     = 32'h0000_0000,
   parameter int          FRAC       = 16,
   parameter int          NORM_SHIFT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] x,
   output logic        ack,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE = 2'd0, LIN = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

   state_t      state_r;
   logic [31:0] x_r;
   logic [31:0] y_r;
   logic        ack_r;
   logic [31:0] result_r;

   logic signed [63:0] prod_s;
   logic signed [63:0] sum_s;
   logic        [31:0] sat_s;

   // Truncating fixed-point to float; y is read as a value with NORM_SHIFT fraction bits.
   function automatic logic [31:0] to_float(input logic [31:0] y);
      logic [31:0] m;
      logic [4:0]  p;
      logic [7:0]  e;
      logic [22:0] mant;
      m = y[31] ? (~y + 32'd1) : y;
      p = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) begin
            p = 5'(i);
         end else begin
            p = p;
         end
      end
      e    = 8'(127 + int'(p) - NORM_SHIFT);
      mant = 23'((m << (5'd31 - p)) >> 8);
      if (y == 32'd0) begin
         to_float = 32'h0000_0000;
      end else begin
         to_float = {y[31], e, mant};
      end
   endfunction

   // Linearization datapath: 64-bit signed product, arithmetic shift, offset, saturation.
   always_comb begin
      prod_s = $signed({{32{x_r[31]}}, x_r}) * $signed({{32{GAIN[31]}}, GAIN});
      sum_s  = (prod_s >>> FRAC) + $signed({{32{OFFSET[31]}}, OFFSET});
      if (sum_s > 64'sh0000_0000_7FFF_FFFF) begin
         sat_s = 32'h7FFF_FFFF;
      end else if (sum_s < 64'shFFFF_FFFF_8000_0000) begin
         sat_s = 32'h8000_0000;
      end else begin
         sat_s = sum_s[31:0];
      end
   end

   // Channel sequencer with registered ack and result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         x_r      <= 32'd0;
         y_r      <= 32'd0;
         ack_r    <= 1'b0;
         result_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               ack_r <= 1'b0;
               if (start) begin
                  x_r     <= x;
                  state_r <= LIN;
               end else begin
                  state_r <= IDLE;
               end
            end
            LIN: begin
               ack_r   <= 1'b0;
               y_r     <= sat_s;
               state_r <= NORM;
            end
            NORM: begin
               result_r <= to_float(y_r);
               ack_r    <= 1'b1;
               state_r  <= DONE;
            end
            DONE: begin
               ack_r   <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ack_r   <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ack    = ack_r;
   assign result = result_r;

endmodule

module linealizador_normalizador_core #(
   parameter logic [31:0] GAIN_I     = 32'h0001_0000,
   parameter logic [31:0] OFFSET_I   = 32'h0000_0000,
   parameter logic [31:0] GAIN_V     = 32'h0001_0000,
   parameter logic [31:0] OFFSET_V   = 32'h0000_0000,
   parameter int          FRAC       = 16,
   parameter int          NORM_SHIFT = 16
) (
   input  logic        CLK,
   input  logic        RST_LN_FF,
   input  logic        Begin_FSM_I,
   input  logic        Begin_FSM_V,
   input  logic [31:0] I,
   input  logic [31:0] V,
   output logic        ACK_I,
   output logic        ACK_V,
   output logic [31:0] RESULT_I,
   output logic [31:0] RESULT_V
);

   linealizador_normalizador_channel #(
      .GAIN(GAIN_I), .OFFSET(OFFSET_I), .FRAC(FRAC), .NORM_SHIFT(NORM_SHIFT)
   ) u_chan_i (
      .clk(CLK), .rst_n(RST_LN_FF), .start(Begin_FSM_I), .x(I),
      .ack(ACK_I), .result(RESULT_I)
   );

   linealizador_normalizador_channel #(
      .GAIN(GAIN_V), .OFFSET(OFFSET_V), .FRAC(FRAC), .NORM_SHIFT(NORM_SHIFT)
   ) u_chan_v (
      .clk(CLK), .rst_n(RST_LN_FF), .start(Begin_FSM_V), .x(V),
      .ack(ACK_V), .result(RESULT_V)
   );

endmodule

// File: tb/tb_linealizador_normalizador_core.sv
// Directed bench: a default-parameter core and a second core with other gains/offsets,
// checked every cycle against a behavioural model plus hand-computed literals.

module tb_linealizador_normalizador_core;

   logic        CLK = 1'b0;
   logic        RST_LN_FF = 1'b1;
   logic        Begin_FSM_I = 1'b0;
   logic        Begin_FSM_V = 1'b0;
   logic [31:0] I = 32'd0;
   logic [31:0] V = 32'd0;

   // channel index: 0 = A.I, 1 = A.V, 2 = B.I, 3 = B.V
   logic        ack_s [4];
   logic [31:0] res_s [4];

   int n_chk  = 0;
   int n_pass = 0;
   int ack_cnt;

   always #5 CLK = ~CLK;

   linealizador_normalizador_core dut_a (
      .CLK(CLK), .RST_LN_FF(RST_LN_FF), .Begin_FSM_I(Begin_FSM_I), .Begin_FSM_V(Begin_FSM_V),
      .I(I), .V(V), .ACK_I(ack_s[0]), .ACK_V(ack_s[1]), .RESULT_I(res_s[0]), .RESULT_V(res_s[1])
   );

   linealizador_normalizador_core #(
      .GAIN_I(32'h0002_0000), .OFFSET_I(32'h0000_0000),
      .GAIN_V(32'hFFFF_8000), .OFFSET_V(32'h0000_0100),
      .FRAC(16), .NORM_SHIFT(16)
   ) dut_b (
      .CLK(CLK), .RST_LN_FF(RST_LN_FF), .Begin_FSM_I(Begin_FSM_I), .Begin_FSM_V(Begin_FSM_V),
      .I(I), .V(V), .ACK_I(ack_s[2]), .ACK_V(ack_s[3]), .RESULT_I(res_s[2]), .RESULT_V(res_s[3])
   );

   function automatic logic [31:0] gain_of(input int c);
      case (c)
         2:       gain_of = 32'h0002_0000;
         3:       gain_of = 32'hFFFF_8000;
         default: gain_of = 32'h0001_0000;
      endcase
   endfunction

   function automatic logic [31:0] offset_of(input int c);
      offset_of = (c == 3) ? 32'h0000_0100 : 32'h0000_0000;
   endfunction

   // Reference: exact integer arithmetic, then float built from exponent search and division.
   function automatic logic [31:0] model_f(input logic [31:0] x, input logic [31:0] g,
                                           input logic [31:0] off, input int frac, input int ns);
      longint y, m, mant;
      int     e;
      logic [7:0] ex;
      y = (longint'($signed(x)) * longint'($signed(g))) >>> frac;
      y = y + longint'($signed(off));
      if (y > 64'sd2147483647) y = 64'sd2147483647;
      if (y < -64'sd2147483648) y = -64'sd2147483648;
      if (y == 0) return 32'h0000_0000;
      m = (y < 0) ? -y : y;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      mant = ((m - (64'sd1 <<< e)) << 23) >> e;
      ex = 8'(127 + e - ns);
      return {(y < 0), ex, mant[22:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Model state: edge counter, per-channel start edge, earliest free edge, captured sample.
   int          cyc = 0;
   int          start_e [4] = '{-100, -100, -100, -100};
   int          next_free [4] = '{0, 0, 0, 0};
   logic [31:0] xs [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
   logic [31:0] exp_res [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

   // Model update on each clock edge; an accepted start produces its result two edges later.
   always @(posedge CLK or negedge RST_LN_FF) begin
      if (!RST_LN_FF) begin
         cyc <= 0;
         for (int c = 0; c < 4; c++) begin
            start_e[c]   <= -100;
            next_free[c] <= 0;
            exp_res[c]   <= 32'd0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int c = 0; c < 4; c++) begin
            if ((cyc + 1 >= next_free[c]) && ((c % 2 == 0) ? Begin_FSM_I : Begin_FSM_V)) begin
               start_e[c]   <= cyc + 1;
               next_free[c] <= cyc + 5;
               xs[c]        <= (c % 2 == 0) ? I : V;
            end
            if (cyc + 1 == start_e[c] + 2)
               exp_res[c] <= model_f(xs[c], gain_of(c), offset_of(c), 16, 16);
         end
      end
   end

   // Every-cycle comparison on the falling edge.
   always @(negedge CLK) begin
      for (int c = 0; c < 4; c++) begin
         if (!RST_LN_FF) begin
            chk("reset_ack", {31'd0, ack_s[c]}, 32'd0);
            chk("reset_result", res_s[c], 32'd0);
         end else begin
            chk("ack", {31'd0, ack_s[c]}, {31'd0, (cyc == start_e[c] + 2)});
            chk("result", res_s[c], exp_res[c]);
         end
      end
   end

   task automatic pulse(input logic bi, input logic bv, input logic [31:0] xi, input logic [31:0] xv);
      @(negedge CLK);
      Begin_FSM_I = bi;
      Begin_FSM_V = bv;
      I = xi;
      V = xv;
      @(negedge CLK);
      Begin_FSM_I = 1'b0;
      Begin_FSM_V = 1'b0;
      I = 32'hDEAD_BEEF;
      V = 32'h1234_5678;
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      // pin the model itself
      chk("model_026_i", model_f(32'hFD28E4FA, 32'h0001_0000, 32'd0, 16, 16), 32'hC435C6C1);
      chk("model_026_v", model_f(32'hB0BCEE61, 32'h0001_0000, 32'd0, 16, 16), 32'hC69E8623);
      chk("model_one", model_f(32'h0000_0001, 32'h0001_0000, 32'd0, 16, 16), 32'h3780_0000);
      chk("model_sat", model_f(32'h7FFF_FFFF, 32'h0002_0000, 32'd0, 16, 16), 32'h46FF_FFFF);

      #1 RST_LN_FF = 1'b0;
      repeat (2) @(negedge CLK);
      #1 RST_LN_FF = 1'b1;

      pulse(1'b1, 1'b1, 32'hFD28E4FA, 32'hB0BCEE61);
      chk("lit_ack_i", {31'd0, ack_s[0]}, 32'd1);
      chk("lit_ack_v", {31'd0, ack_s[1]}, 32'd1);
      chk("lit_026_i", res_s[0], 32'hC435C6C1);
      chk("lit_026_v", res_s[1], 32'hC69E8623);

      pulse(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0100);
      chk("lit_zero", res_s[0], 32'h0000_0000);
      pulse(1'b1, 1'b0, 32'h0000_0001, 32'h0);
      chk("lit_one_lsb", res_s[0], 32'h3780_0000);
      pulse(1'b1, 1'b0, 32'h0001_0000, 32'h0);
      chk("lit_unity", res_s[0], 32'h3F80_0000);

      pulse(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
      chk("lit_sat_pos", res_s[2], 32'h46FF_FFFF);
      pulse(1'b1, 1'b0, 32'h8000_0000, 32'h0);
      chk("lit_sat_neg", res_s[2], 32'hC700_0000);

      // Begin held high for 12 cycles with the sample changing every cycle
      ack_cnt = 0;
      @(negedge CLK);
      Begin_FSM_I = 1'b1;
      Begin_FSM_V = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (ack_s[0]) ack_cnt++;
         I = 32'h0001_0000 + 32'(k) * 32'h0000_3100;
         V = 32'hFFF0_0000 - 32'(k) * 32'h0000_0777;
      end
      Begin_FSM_I = 1'b0;
      Begin_FSM_V = 1'b0;
      chk("held_ack_count", 32'(ack_cnt), 32'd3);
      repeat (4) @(negedge CLK);

      // reset while both channels sit in NORM
      @(negedge CLK);
      Begin_FSM_I = 1'b1;
      Begin_FSM_V = 1'b1;
      I = 32'h0003_0000;
      V = 32'h0005_0000;
      @(negedge CLK);
      Begin_FSM_I = 1'b0;
      Begin_FSM_V = 1'b0;
      @(negedge CLK);
      #1 RST_LN_FF = 1'b0;
      #1;
      chk("midreset_res_i", res_s[0], 32'd0);
      chk("midreset_res_v", res_s[3], 32'd0);
      chk("midreset_ack", {31'd0, ack_s[0]}, 32'd0);
      @(negedge CLK);
      #1 RST_LN_FF = 1'b1;
      repeat (3) @(negedge CLK);

      pulse(1'b1, 1'b1, 32'h0001_0000, 32'h0000_0001);
      chk("post_reset_i", res_s[0], 32'h3F80_0000);
      chk("post_reset_v", res_s[1], 32'h3780_0000);

      // only V started
      pulse(1'b0, 1'b1, 32'h0002_0000, 32'h0001_0000);
      chk("vonly_ack_i", {31'd0, ack_s[0]}, 32'd0);
      chk("vonly_res_i", res_s[0], 32'h3F80_0000);
      chk("vonly_res_v", res_s[1], 32'h3F80_0000);
      repeat (3) @(negedge CLK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
